// File: rtl/mini_rv_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// | Package : mini_rv_pkg                                                    |
// | Shared opcode, ALU-op and sequencer state encodings for the Mini RISC-V  |
// | multi-cycle control path.                                                |
// | Rev 1.0 : initial release                                                |
// ---------------------------------------------------------------------------
package mini_rv_pkg;

  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_LW    = 7'b0000011;
  localparam logic [6:0] OP_SW    = 7'b0100011;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_MEM    = 3'd4;
  localparam logic [2:0] S_WB     = 3'd5;
  localparam logic [2:0] S_ERROR  = 3'd7;

  // True for the four opcodes the sequencer knows how to execute
  function automatic logic is_supported(input logic [6:0] op);
    return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) || (op == OP_BEQ);
  endfunction

endpackage
`default_nettype wire

// File: rtl/ctrl_wait_timer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// | Module  : ctrl_wait_timer                                                |
// | Counts memory stall cycles; expired flags the stall cycle that would be  |
// | the MAX_WAIT-th consecutive one, so the sequencer leaves on that edge.   |
// | Rev 1.0 : initial release                                                |
// ---------------------------------------------------------------------------
module ctrl_wait_timer #(
  parameter int MAX_WAIT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic en,
  output logic expired
);

  localparam int              c_W    = $clog2(MAX_WAIT + 1);
  localparam logic [c_W-1:0]  c_LAST = c_W'(MAX_WAIT - 1);

  logic [c_W-1:0] r_count;

  // Stall counter: restarts on every state change, advances on stall cycles
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (clear) begin
      r_count <= '0;
    end else if (en) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign expired = en && (r_count == c_LAST);

endmodule
`default_nettype wire

// File: rtl/multicycle_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// | Module  : multicycle_ctrl                                                |
// | FETCH/DECODE/EXEC/MEM/WB sequencer for the Mini RISC-V shared datapath,  |
// | with memory ready handshake and sticky timeout error state.              |
// | Option  : CTRL_PERF_CNT_EN adds cycle_cnt / instr_cnt outputs.           |
// | Rev 1.0 : initial release                                                |
// ---------------------------------------------------------------------------
module multicycle_ctrl #(
  parameter int MAX_WAIT = 15
`ifdef CTRL_PERF_CNT_EN
  , parameter int CNT_W = 32
`endif
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_src,
  output logic       ir_write,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       reg_write,
  output logic       mem_to_reg,
  output logic       alu_src,
  output logic [1:0] alu_op,
  output logic       instr_done,
  output logic       illegal_instr,
  output logic       err,
  output logic [2:0] state
`ifdef CTRL_PERF_CNT_EN
  , output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instr_cnt
`endif
);

  import mini_rv_pkg::*;

  logic [2:0] r_state;
  logic [2:0] w_state_next;
  logic       w_stall;
  logic       w_expired;

  assign w_stall = ((r_state == S_FETCH) || (r_state == S_MEM)) && !mem_ready;

  ctrl_wait_timer #(
    .MAX_WAIT (MAX_WAIT)
  ) u_wait_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (w_state_next != r_state),
    .en      (w_stall),
    .expired (w_expired)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic; a ready in the same cycle as expiry wins over the timeout
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:   w_state_next = S_FETCH;
      S_FETCH: begin
        if (mem_ready)      w_state_next = S_DECODE;
        else if (w_expired) w_state_next = S_ERROR;
      end
      S_DECODE: w_state_next = is_supported(opcode) ? S_EXEC : S_FETCH;
      S_EXEC: begin
        if (opcode == OP_RTYPE)                        w_state_next = S_WB;
        else if ((opcode == OP_LW) || (opcode == OP_SW)) w_state_next = S_MEM;
        else                                           w_state_next = S_FETCH;
      end
      S_MEM: begin
        if (mem_ready)      w_state_next = (opcode == OP_LW) ? S_WB : S_FETCH;
        else if (w_expired) w_state_next = S_ERROR;
      end
      S_WB:     w_state_next = S_FETCH;
      S_ERROR:  w_state_next = S_ERROR;
      default:  w_state_next = S_IDLE;
    endcase
  end

  // Output decode; requests depend only on state/opcode so they hold steady during waits
  always_comb begin
    pc_write      = 1'b0;
    pc_src        = 1'b0;
    ir_write      = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    reg_write     = 1'b0;
    mem_to_reg    = 1'b0;
    alu_src       = 1'b0;
    alu_op        = ALUOP_ADD;
    instr_done    = 1'b0;
    illegal_instr = 1'b0;
    err           = 1'b0;
    case (r_state)
      S_FETCH: begin
        mem_read = 1'b1;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
        end
      end
      S_DECODE: illegal_instr = !is_supported(opcode);
      S_EXEC: begin
        if (opcode == OP_RTYPE) begin
          alu_op = ALUOP_FUNCT;
        end else if ((opcode == OP_LW) || (opcode == OP_SW)) begin
          alu_src = 1'b1;
        end else if (opcode == OP_BEQ) begin
          alu_op     = ALUOP_SUB;
          pc_write   = zero;
          pc_src     = zero;
          instr_done = 1'b1;
        end
      end
      S_MEM: begin
        i_or_d    = 1'b1;
        alu_src   = 1'b1;
        mem_read  = (opcode == OP_LW);
        mem_write = (opcode == OP_SW);
        instr_done = mem_ready && (opcode == OP_SW);
      end
      S_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = (opcode == OP_LW);
        instr_done = 1'b1;
      end
      S_ERROR:  err = 1'b1;
      default: ;
    endcase
  end

  assign state = r_state;

`ifdef CTRL_PERF_CNT_EN
  logic [CNT_W-1:0] r_cycle_cnt;
  logic [CNT_W-1:0] r_instr_cnt;

  // Active-cycle and retirement counters, wrapping naturally
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cycle_cnt <= '0;
      r_instr_cnt <= '0;
    end else begin
      if ((r_state != S_IDLE) && (r_state != S_ERROR)) r_cycle_cnt <= r_cycle_cnt + 1'b1;
      if (instr_done) r_instr_cnt <= r_instr_cnt + 1'b1;
    end
  end

  assign cycle_cnt = r_cycle_cnt;
  assign instr_cnt = r_instr_cnt;
`else
  // Performance counters are not built in this configuration
`endif

endmodule
`default_nettype wire

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
Multi-cycle sequencer for the Mini RISC-V core. It steps one shared ALU/memory datapath through the phases FETCH, DECODE, EXEC, MEM and WB for R-type, LW, SW and BEQ. It drives per-phase enables, handles memory wait-states through a ready handshake, and enters a sticky error state on memory timeout. It sits between the instruction register's opcode field and the datapath muxes and enables.

Parameters:
MAX_WAIT, 15, cycles mem_ready may stay low in FETCH/MEM before ERROR (1..255)
CNT_W, 32, width of performance counters (only with CTRL_PERF_CNT_EN)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
opcode  in  7  instr[6:0] from IR; valid from DECODE onward
zero  in  1  ALU zero flag
mem_ready  in  1  memory accepts/returns access this cycle
pc_write  out  1  update PC
pc_src  out  1  0=PC+4, 1=branch target
ir_write  out  1  load IR from memory read data
i_or_d  out  1  memory address: 0=PC, 1=ALU result
mem_read  out  1  memory read request
mem_write  out  1  memory write request
reg_write  out  1  register file write
mem_to_reg  out  1  WB source: 0=ALU, 1=memory data
alu_src  out  1  ALU B: 0=rs2, 1=immediate
alu_op  out  2  00=add, 01=sub/compare, 10=funct decode
instr_done  out  1  one-cycle pulse on instruction retirement
illegal_instr  out  1  one-cycle pulse, unsupported opcode in DECODE
err  out  1  sticky memory-timeout flag
state  out  3  current state (debug)

Behaviour:
- State encoding: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, ERROR=7. Registered state; outputs decoded combinationally from state, opcode, zero and mem_ready.
- Reset (async): state=IDLE, wait counter=0. In IDLE all outputs are 0 and state=0. IDLE goes to FETCH on the first clock edge after rst deasserts.
- FETCH: mem_read=1, i_or_d=0. While mem_ready=0, hold. On the mem_ready=1 cycle: ir_write=1, pc_write=1, pc_src=0; go to DECODE.
- DECODE: one cycle, no enables.
  - Opcode 0110011, 0000011, 0100011 or 1100011: go to EXEC.
  - Any other opcode: illegal_instr=1; go to FETCH. PC has already advanced, so the instruction is skipped.
- EXEC:
  - R-type: alu_src=0, alu_op=10; go to WB.
  - LW/SW: alu_src=1, alu_op=00; go to MEM.
  - BEQ: alu_src=0, alu_op=01. If zero=1: pc_write=1, pc_src=1. Always instr_done=1; go to FETCH.
- MEM: i_or_d=1, alu_src=1, alu_op=00. LW asserts mem_read; SW asserts mem_write. Hold while mem_ready=0. On mem_ready=1: LW goes to WB; SW asserts instr_done=1 and goes to FETCH.
- WB: reg_write=1, mem_to_reg=1 for LW, 0 for R-type; instr_done=1; go to FETCH.
- Latency with zero wait-states, FETCH to retirement: BEQ 3, R-type 4, SW 4, LW 5 cycles. Each memory wait cycle adds 1.
- Wait counter:
  - Cleared on every state change.
  - Increments each FETCH/MEM cycle with mem_ready=0.
  - If the counter equals MAX_WAIT while mem_ready=0, go to ERROR on that edge.
  - mem_ready=1 in the same cycle wins: no error.
- ERROR: all enables 0, err=1, state=7. Exit only via rst; err clears on reset.
- Request stability: mem_read/mem_write and i_or_d stay constant throughout a wait. Requests never drop before mem_ready.
- rst asserted mid-instruction: immediate return to IDLE. No partial write enable survives the reset.

Optional Feature:
CTRL_PERF_CNT_EN.
- Defined: adds outputs cycle_cnt[CNT_W-1:0] and instr_cnt[CNT_W-1:0].
  - cycle_cnt increments every clock outside IDLE and ERROR.
  - instr_cnt increments on each instr_done.
  - Both reset to 0 and wrap modulo 2^CNT_W.
- Undefined: ports and logic absent; behaviour otherwise identical.

Decomposition:
- Package mini_rv_pkg: opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ), ALU op codes (ALUOP_ADD, ALUOP_SUB, ALUOP_FUNCT), state encodings.
- One sub-module: ctrl_wait_timer. Inputs: clear, count enable. Output: expired at MAX_WAIT. Width is $clog2(MAX_WAIT+1).

Test Plan:
- Reset then R-type (0110011), mem_ready=1: states 0,1,2,3,5,1. ir_write and pc_write at cycle 1, reg_write=1 with mem_to_reg=0 at cycle 4, one instr_done.
- LW with 2 wait-cycles in MEM: mem_read and i_or_d=1 held 3 cycles; WB has reg_write=1, mem_to_reg=1. Total 7 cycles.
- BEQ with zero=1 then zero=0: first gives pc_write=1, pc_src=1 in EXEC; second gives pc_write=0. Both retire in 3 cycles.
- Opcode 7'b1111111: illegal_instr pulse in DECODE, no reg_write/mem_write, next state FETCH.
- mem_ready held 0 in FETCH with MAX_WAIT=15: ERROR entered after 15 cycles, err=1 and sticky. rst clears to IDLE, err=0.
- rst pulsed during SW's MEM wait: state 0 asynchronously, mem_write=0 immediately. With CTRL_PERF_CNT_EN, counters read 0.
